// File: rtl/qif_neuron_scheduler_pkg.sv
// Shared definitions for the QIF neuron scheduler: default datapath
// parameters, the sweep state encoding and the saturation limits.
package qif_pkg;

   localparam int DEF_WIDTH        = 8;
   localparam int DEF_V_THRESH     = 50;
   localparam int DEF_V_RESET      = -20;
   localparam int DEF_REFRAC_TICKS = 2;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      DONE
   } state_t;

   // Largest value representable in a signed w-bit word
   function automatic int satMax(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   // Smallest value representable in a signed w-bit word
   function automatic int satMin(input int w);
      return -(1 << (w - 1));
   endfunction

endpackage

// File: rtl/qif_neuron_scheduler_update_core.sv
// Combinational QIF membrane update for one neuron:
//    V >= threshold : V <- V_RESET, spike
//    otherwise      : V <- sat(V + (I >>> 2) + (V >>> 3)^2)
// The sum is formed three bits wider than the state so that the square
// term cannot wrap before saturation.
module qif_update_core
   import qif_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int V_THRESH = DEF_V_THRESH,
   parameter int V_RESET  = DEF_V_RESET
) (
   input  logic signed [WIDTH-1:0] v_i,
   input  logic signed [WIDTH-1:0] i_i,
   input  logic                    refrac_i,
   output logic signed [WIDTH-1:0] v_next_o,
   output logic                    spike_o
);

   localparam int SW = WIDTH + 3;
   localparam logic signed [WIDTH-1:0] THRESH = WIDTH'(V_THRESH);
   localparam logic signed [WIDTH-1:0] RESETV = WIDTH'(V_RESET);
   localparam logic signed [SW-1:0]    MAXW   = SW'(satMax(WIDTH));
   localparam logic signed [SW-1:0]    MINW   = SW'(satMin(WIDTH));

   logic signed [WIDTH-1:0] iQuarter;
   logic signed [WIDTH-1:0] vEighth;
   logic signed [SW-1:0]    vW;
   logic signed [SW-1:0]    iQuarterW;
   logic signed [SW-1:0]    vEighthW;
   logic signed [SW-1:0]    squareW;
   logic signed [SW-1:0]    sumW;

   // Widen operands, form the quadratic sum and pick reset, saturated or plain result
   always_comb begin
      iQuarter  = i_i >>> 2;
      vEighth   = v_i >>> 3;
      vW        = {{3{v_i[WIDTH-1]}}, v_i};
      iQuarterW = {{3{iQuarter[WIDTH-1]}}, iQuarter};
      vEighthW  = {{3{vEighth[WIDTH-1]}}, vEighth};
      squareW   = vEighthW * vEighthW;
      sumW      = vW + iQuarterW + squareW;
      v_next_o  = RESETV;
      spike_o   = 1'b0;
      if (refrac_i) begin
         v_next_o = RESETV;
      end else if (v_i >= THRESH) begin
         v_next_o = RESETV;
         spike_o  = 1'b1;
      end else if (sumW > MAXW) begin
         v_next_o = MAXW[WIDTH-1:0];
      end else if (sumW < MINW) begin
         v_next_o = MINW[WIDTH-1:0];
      end else begin
         v_next_o = sumW[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/qif_neuron_scheduler.sv
// QIF neuron scheduler: one shared update core swept across N_NEURONS
// membrane/current register pairs, two cycles per neuron plus a DONE cycle.
// Optional feature macro: QIF_SCHED_REFRACTORY_EN adds a per-neuron
// refractory counter that holds V at V_RESET for REFRAC_TICKS sweeps after
// a spike.
module qif_neuron_scheduler
   import qif_pkg::*;
#(
   parameter int N_NEURONS    = 4,
   parameter int WIDTH        = DEF_WIDTH,
   parameter int V_THRESH     = DEF_V_THRESH,
   parameter int V_RESET      = DEF_V_RESET,
   parameter int REFRAC_TICKS = DEF_REFRAC_TICKS
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         tick,
   input  logic                         wr_en,
   input  logic [$clog2(N_NEURONS)-1:0] wr_addr,
   input  logic signed [WIDTH-1:0]      wr_data,
   output logic                         busy,
   output logic                         done,
   output logic                         out_valid,
   output logic [$clog2(N_NEURONS)-1:0] out_addr,
   output logic signed [WIDTH-1:0]      v_mem_out,
   output logic                         spike_out,
   output logic [N_NEURONS-1:0]         spike_vec,
   output logic                         overrun
);

   localparam int AW = $clog2(N_NEURONS);
   localparam logic [AW-1:0] LAST_IDX = AW'(N_NEURONS - 1);

   state_t                  state_q;
   logic [AW-1:0]           idx_q;
   logic signed [WIDTH-1:0] vMem_q [N_NEURONS];
   logic signed [WIDTH-1:0] iSyn_q [N_NEURONS];
   logic signed [WIDTH-1:0] opV_q;
   logic signed [WIDTH-1:0] opI_q;
   logic [N_NEURONS-1:0]    spikeAcc_q;
   logic [N_NEURONS-1:0]    spikeVec_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    outValid_q;
   logic [AW-1:0]           outAddr_q;
   logic signed [WIDTH-1:0] vMemOut_q;
   logic                    spikeOut_q;
   logic                    overrun_q;

   logic signed [WIDTH-1:0] vNext_d;
   logic                    spikeNext_d;
   logic                    refracActive;

`ifdef QIF_SCHED_REFRACTORY_EN
   localparam int RW = (REFRAC_TICKS > 0) ? $clog2(REFRAC_TICKS + 1) : 1;
   logic [RW-1:0] refrac_q [N_NEURONS];
   assign refracActive = (refrac_q[idx_q] != '0);
`else
   assign refracActive = 1'b0;
`endif

   qif_update_core #(
      .WIDTH    (WIDTH),
      .V_THRESH (V_THRESH),
      .V_RESET  (V_RESET)
   ) u_core (
      .v_i      (opV_q),
      .i_i      (opI_q),
      .refrac_i (refracActive),
      .v_next_o (vNext_d),
      .spike_o  (spikeNext_d)
   );

   // Synaptic current writes are accepted in every state; a READ in the same cycle sees the old value
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N_NEURONS; i++) iSyn_q[i] <= '0;
      end else if (wr_en) begin
         iSyn_q[wr_addr] <= wr_data;
      end
   end

   // Sweep FSM: READ latches operands, WRITE commits the update and presents it, DONE publishes spikes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         opV_q      <= '0;
         opI_q      <= '0;
         spikeAcc_q <= '0;
         spikeVec_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         outValid_q <= 1'b0;
         outAddr_q  <= '0;
         vMemOut_q  <= '0;
         spikeOut_q <= 1'b0;
         overrun_q  <= 1'b0;
         for (int i = 0; i < N_NEURONS; i++) vMem_q[i] <= '0;
`ifdef QIF_SCHED_REFRACTORY_EN
         for (int i = 0; i < N_NEURONS; i++) refrac_q[i] <= '0;
`endif
      end else begin
         done_q     <= 1'b0;
         outValid_q <= 1'b0;
         if (tick && (state_q != IDLE)) overrun_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (tick) begin
                  state_q    <= READ;
                  idx_q      <= '0;
                  busy_q     <= 1'b1;
                  spikeAcc_q <= '0;
               end
            end
            READ: begin
               opV_q   <= vMem_q[idx_q];
               opI_q   <= iSyn_q[idx_q];
               state_q <= WRITE;
            end
            WRITE: begin
               vMem_q[idx_q]     <= vNext_d;
               outValid_q        <= 1'b1;
               outAddr_q         <= idx_q;
               vMemOut_q         <= vNext_d;
               spikeOut_q        <= spikeNext_d;
               spikeAcc_q[idx_q] <= spikeNext_d;
`ifdef QIF_SCHED_REFRACTORY_EN
               if (refracActive) begin
                  refrac_q[idx_q] <= refrac_q[idx_q] - RW'(1);
               end else if (spikeNext_d) begin
                  refrac_q[idx_q] <= RW'(REFRAC_TICKS);
               end
`endif
               if (idx_q == LAST_IDX) begin
                  state_q <= DONE;
               end else begin
                  idx_q   <= idx_q + AW'(1);
                  state_q <= READ;
               end
            end
            DONE: begin
               done_q     <= 1'b1;
               busy_q     <= 1'b0;
               spikeVec_q <= spikeAcc_q;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign out_valid = outValid_q;
   assign out_addr  = outAddr_q;
   assign v_mem_out = vMemOut_q;
   assign spike_out = spikeOut_q;
   assign spike_vec = spikeVec_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_qif_neuron_scheduler.sv
// Testbench for qif_neuron_scheduler. Two instances share all inputs: one
// with the default threshold (50) and one with threshold 127 so the
// saturation path is reachable. A behavioural model of the neuron
// equations predicts every presented result and the spike vector.
module tb_qif_neuron_scheduler;

   localparam int N = 4;
   localparam int SWEEP_LIMIT = 40;
   localparam int LAT = 2 * N + 1;

   logic clk = 1'b0;
   logic rst_n;
   logic tick;
   logic wr_en;
   logic [1:0] wr_addr;
   logic signed [7:0] wr_data;

   wire [1:0] busyO, doneO, validO, spkO, ovO;
   wire [1:0] addrO [2];
   wire signed [7:0] vO [2];
   wire [N-1:0] vecO [2];

   int passCnt = 0;
   int totalCnt = 0;

   // Model state: per-instance membrane and refractory, shared currents
   int thr [2] = '{50, 127};
   int mV [2][N];
   int mR [2][N];
   int mI [N];
   logic [N-1:0] mVec [2];
   logic [N-1:0] prevVec [2];
   int expV [2][N];
   bit expS [2][N];
   logic [N-1:0] expVec [2];

   // Observations captured from one sweep
   int obsAddr [2][N];
   int obsV [2][N];
   bit obsS [2][N];
   int obsCnt [2];
   int obsLat [2];
   logic [N-1:0] obsVec [2];
   logic [N-1:0] obsVecBefore [2];
   logic obsBusyAtDone [2];

   qif_neuron_scheduler dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busyO[0]), .done(doneO[0]), .out_valid(validO[0]), .out_addr(addrO[0]),
      .v_mem_out(vO[0]), .spike_out(spkO[0]), .spike_vec(vecO[0]), .overrun(ovO[0])
   );

   qif_neuron_scheduler #(.V_THRESH(127)) dutSat (
      .clk(clk), .rst_n(rst_n), .tick(tick), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busyO[1]), .done(doneO[1]), .out_valid(validO[1]), .out_addr(addrO[1]),
      .v_mem_out(vO[1]), .spike_out(spkO[1]), .spike_vec(vecO[1]), .overrun(ovO[1])
   );

   always #5 clk = ~clk;

   function automatic int floorDiv(input int a, input int b);
      if (a >= 0) return a / b;
      return -((-a + b - 1) / b);
   endfunction

   function automatic int clamp8(input int x);
      if (x > 127) return 127;
      if (x < -128) return -128;
      return x;
   endfunction

   task automatic modelReset();
      for (int k = 0; k < 2; k++) begin
         for (int n = 0; n < N; n++) begin
            mV[k][n] = 0;
            mR[k][n] = 0;
         end
         mVec[k] = '0;
      end
      for (int n = 0; n < N; n++) mI[n] = 0;
   endtask

   // Predict one full sweep from the neuron equations and advance the model
   task automatic modelSweep();
      int q;
      for (int k = 0; k < 2; k++) begin
         prevVec[k] = mVec[k];
         for (int n = 0; n < N; n++) begin
            expS[k][n] = 1'b0;
`ifdef QIF_SCHED_REFRACTORY_EN
            if (mR[k][n] > 0) begin
               expV[k][n] = -20;
               mR[k][n] = mR[k][n] - 1;
            end else
`endif
            if (mV[k][n] >= thr[k]) begin
               expV[k][n] = -20;
               expS[k][n] = 1'b1;
               mR[k][n] = 2;
            end else begin
               q = floorDiv(mV[k][n], 8);
               expV[k][n] = clamp8(mV[k][n] + floorDiv(mI[n], 4) + q * q);
            end
            mV[k][n] = expV[k][n];
            expVec[k][n] = expS[k][n];
         end
         mVec[k] = expVec[k];
      end
   endtask

   task automatic writeCurrent(input int a, input int d);
      wr_en = 1'b1;
      wr_addr = 2'(a);
      wr_data = 8'(d);
      @(posedge clk); #1;
      wr_en = 1'b0;
      mI[a] = d;
   endtask

   // Fire one tick and record everything both instances present until done
   task automatic runSweep(input int wCycle, input int wAddr, input int wData, input int tickCycle);
      int firstBusy;
      int cnt [2];
      int doneCyc [2];
      modelSweep();
      firstBusy = -1;
      for (int k = 0; k < 2; k++) begin
         cnt[k] = 0;
         doneCyc[k] = -1;
         obsVec[k] = 'x;
         obsBusyAtDone[k] = 1'bx;
         for (int n = 0; n < N; n++) begin
            obsAddr[k][n] = -1;
            obsV[k][n] = 999;
            obsS[k][n] = 1'b0;
         end
      end
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      for (int cyc = 1; cyc <= SWEEP_LIMIT; cyc++) begin
         if (cyc == 1) for (int k = 0; k < 2; k++) obsVecBefore[k] = vecO[k];
         if (busyO[0] && firstBusy < 0) firstBusy = cyc;
         for (int k = 0; k < 2; k++) begin
            if (validO[k]) begin
               if (cnt[k] < N) begin
                  obsAddr[k][cnt[k]] = int'(addrO[k]);
                  obsV[k][cnt[k]] = vO[k];
                  obsS[k][cnt[k]] = spkO[k];
               end
               cnt[k]++;
            end
            if (doneO[k] && doneCyc[k] < 0) begin
               doneCyc[k] = cyc;
               obsVec[k] = vecO[k];
               obsBusyAtDone[k] = busyO[k];
            end
         end
         if (doneCyc[0] >= 0 && doneCyc[1] >= 0) break;
         tick = (cyc == tickCycle);
         wr_en = (cyc == wCycle);
         if (cyc == wCycle) begin
            wr_addr = 2'(wAddr);
            wr_data = 8'(wData);
         end
         @(posedge clk); #1;
      end
      tick = 1'b0;
      wr_en = 1'b0;
      for (int k = 0; k < 2; k++) begin
         obsCnt[k] = cnt[k];
         obsLat[k] = (doneCyc[k] >= 0 && firstBusy >= 0) ? doneCyc[k] - firstBusy : -1;
      end
      if (wCycle >= 0) mI[wAddr] = wData;
   endtask

   // Reset state of both instances
   task automatic test_reset();
      rst_n = 1'b0;
      tick = 1'b0;
      wr_en = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      repeat (3) @(posedge clk);
      #1;
      modelReset();
      for (int k = 0; k < 2; k++) begin
         totalCnt++;
         if ({busyO[k], doneO[k], validO[k], spkO[k], ovO[k]} !== 5'b0 || addrO[k] !== 2'd0 ||
             vO[k] !== 8'sd0 || vecO[k] !== '0)
            $display("[TB] FAIL reset inst%0d: got busy=%b done=%b valid=%b spike=%b ovr=%b addr=%0d v=%0d vec=%b, want all zero",
                     k, busyO[k], doneO[k], validO[k], spkO[k], ovO[k], addrO[k], vO[k], vecO[k]);
         else passCnt++;
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // All currents zero: four zero results in address order, done 2N+1 cycles after busy
   task automatic test_zero_sweep();
      runSweep(-1, 0, 0, -1);
      for (int k = 0; k < 2; k++) begin
         for (int n = 0; n < N; n++) begin
            totalCnt++;
            if (obsAddr[k][n] !== n || obsV[k][n] !== expV[k][n] || obsS[k][n] !== expS[k][n])
               $display("[TB] FAIL zero k%0d n%0d: got addr=%0d v=%0d spike=%0b, want addr=%0d v=%0d spike=%0b",
                        k, n, obsAddr[k][n], obsV[k][n], obsS[k][n], n, expV[k][n], expS[k][n]);
            else passCnt++;
         end
         totalCnt++;
         if (obsLat[k] !== LAT || obsCnt[k] !== N || obsBusyAtDone[k] !== 1'b0)
            $display("[TB] FAIL zero_timing k%0d: got latency=%0d results=%0d busyAtDone=%b, want %0d %0d 0",
                     k, obsLat[k], obsCnt[k], obsBusyAtDone[k], LAT, N);
         else passCnt++;
         totalCnt++;
         if (obsVec[k] !== '0)
            $display("[TB] FAIL zero_vec k%0d: got %b, want 0000", k, obsVec[k]);
         else passCnt++;
      end
   endtask

   // Ramp to spike on neuron 0, saturation on neuron 1, negative current on neuron 2
   task automatic test_ramp();
      int rampV0 [5] = '{10, 21, 35, 61, -20};
      int satV1 [3] = '{31, 71, 127};
      int negV2 [2] = '{-32, -48};
      writeCurrent(0, 40);
      writeCurrent(1, 127);
      writeCurrent(2, -128);
      writeCurrent(3, 0);
      for (int s = 0; s < 5; s++) begin
         runSweep(-1, 0, 0, -1);
         totalCnt++;
         if (obsV[0][0] !== rampV0[s] || obsS[0][0] !== (s == 4))
            $display("[TB] FAIL ramp_v0 sweep%0d: got v=%0d spike=%0b, want v=%0d spike=%0b",
                     s, obsV[0][0], obsS[0][0], rampV0[s], (s == 4));
         else passCnt++;
         if (s < 3) begin
            totalCnt++;
            if (obsV[1][1] !== satV1[s])
               $display("[TB] FAIL sat_v1 sweep%0d: got %0d, want %0d", s, obsV[1][1], satV1[s]);
            else passCnt++;
         end
         if (s < 2) begin
            totalCnt++;
            if (obsV[0][2] !== negV2[s])
               $display("[TB] FAIL neg_v2 sweep%0d: got %0d, want %0d", s, obsV[0][2], negV2[s]);
            else passCnt++;
         end
         for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < N; n++) begin
               totalCnt++;
               if (obsAddr[k][n] !== n || obsV[k][n] !== expV[k][n] || obsS[k][n] !== expS[k][n])
                  $display("[TB] FAIL ramp_model s%0d k%0d n%0d: got addr=%0d v=%0d spike=%0b, want addr=%0d v=%0d spike=%0b",
                           s, k, n, obsAddr[k][n], obsV[k][n], obsS[k][n], n, expV[k][n], expS[k][n]);
               else passCnt++;
            end
            totalCnt++;
            if (obsVec[k] !== expVec[k] || obsVecBefore[k] !== prevVec[k])
               $display("[TB] FAIL ramp_vec s%0d k%0d: got %b (held %b), want %b (held %b)",
                        s, k, obsVec[k], obsVecBefore[k], expVec[k], prevVec[k]);
            else passCnt++;
         end
      end
      totalCnt++;
      if (obsVec[0][0] !== 1'b1)
         $display("[TB] FAIL ramp_spike_vec0: got %b, want 1", obsVec[0][0]);
      else passCnt++;
   endtask

   // A tick during a sweep is ignored but latches the sticky overrun flag
   task automatic test_overrun();
      totalCnt++;
      if (ovO !== 2'b00) $display("[TB] FAIL overrun_initial: got %b, want 00", ovO);
      else passCnt++;
      for (int pass = 0; pass < 2; pass++) begin
         runSweep(-1, 0, 0, (pass == 0) ? 3 : -1);
         for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < N; n++) begin
               totalCnt++;
               if (obsAddr[k][n] !== n || obsV[k][n] !== expV[k][n] || obsS[k][n] !== expS[k][n])
                  $display("[TB] FAIL overrun_result p%0d k%0d n%0d: got v=%0d spike=%0b, want v=%0d spike=%0b",
                           pass, k, n, obsV[k][n], obsS[k][n], expV[k][n], expS[k][n]);
               else passCnt++;
            end
            totalCnt++;
            if (obsLat[k] !== LAT || obsCnt[k] !== N)
               $display("[TB] FAIL overrun_timing p%0d k%0d: got latency=%0d results=%0d, want %0d %0d",
                        pass, k, obsLat[k], obsCnt[k], LAT, N);
            else passCnt++;
         end
         @(posedge clk); #1;
         totalCnt++;
         if (ovO !== 2'b11) $display("[TB] FAIL overrun_flag p%0d: got %b, want 11", pass, ovO);
         else passCnt++;
      end
   endtask

   // Write to neuron 2 in the cycle it is read: old current this sweep, new current next sweep
   task automatic test_write_collision();
      int newI;
      newI = int'($urandom_range(0, 255)) - 128;
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 0) runSweep(2 * 2 + 1, 2, newI, -1);
         else runSweep(-1, 0, 0, -1);
         for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < N; n++) begin
               totalCnt++;
               if (obsAddr[k][n] !== n || obsV[k][n] !== expV[k][n] || obsS[k][n] !== expS[k][n])
                  $display("[TB] FAIL collision p%0d k%0d n%0d (I=%0d): got v=%0d spike=%0b, want v=%0d spike=%0b",
                           pass, k, n, newI, obsV[k][n], obsS[k][n], expV[k][n], expS[k][n]);
               else passCnt++;
            end
         end
      end
   endtask

   // Random currents written between sweeps, checked sweep by sweep against the model
   task automatic test_random();
      int nW;
      for (int it = 0; it < 8; it++) begin
         nW = int'($urandom_range(0, 3));
         for (int w = 0; w < nW; w++)
            writeCurrent(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)) - 128);
         runSweep(-1, 0, 0, -1);
         for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < N; n++) begin
               totalCnt++;
               if (obsAddr[k][n] !== n || obsV[k][n] !== expV[k][n] || obsS[k][n] !== expS[k][n])
                  $display("[TB] FAIL random it%0d k%0d n%0d: got addr=%0d v=%0d spike=%0b, want addr=%0d v=%0d spike=%0b",
                           it, k, n, obsAddr[k][n], obsV[k][n], obsS[k][n], n, expV[k][n], expS[k][n]);
               else passCnt++;
            end
            totalCnt++;
            if (obsVec[k] !== expVec[k] || obsLat[k] !== LAT)
               $display("[TB] FAIL random_done it%0d k%0d: got vec=%b latency=%0d, want vec=%b latency=%0d",
                        it, k, obsVec[k], obsLat[k], expVec[k], LAT);
            else passCnt++;
         end
      end
   endtask

   // Reset during a WRITE abandons the sweep without a done pulse and clears all state
   task automatic test_mid_sweep_reset();
      bit sawDone;
      writeCurrent(1, 100);
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      modelReset();
      totalCnt++;
      if (busyO !== 2'b00 || validO !== 2'b00 || ovO !== 2'b00)
         $display("[TB] FAIL midreset_state: got busy=%b valid=%b ovr=%b, want 00 00 00", busyO, validO, ovO);
      else passCnt++;
      sawDone = 1'b0;
      for (int c = 0; c < 15; c++) begin
         if (doneO !== 2'b00) sawDone = 1'b1;
         @(posedge clk); #1;
      end
      totalCnt++;
      if (sawDone) $display("[TB] FAIL midreset_done: got done pulse, want none");
      else passCnt++;
      runSweep(-1, 0, 0, -1);
      for (int k = 0; k < 2; k++) begin
         for (int n = 0; n < N; n++) begin
            totalCnt++;
            if (obsAddr[k][n] !== n || obsV[k][n] !== expV[k][n] || obsS[k][n] !== expS[k][n])
               $display("[TB] FAIL midreset_sweep k%0d n%0d: got v=%0d spike=%0b, want v=%0d spike=%0b",
                        k, n, obsV[k][n], obsS[k][n], expV[k][n], expS[k][n]);
            else passCnt++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_zero_sweep();
      test_ramp();
      test_overrun();
      test_write_collision();
      test_random();
      test_mid_sweep_reset();
      $display("[TB] %0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
